// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator with stall-safe redirect/flush
// capture and epoch tagging. Optional macro PC_GEN_MISALIGN_TRAP_EN halts on
// misaligned targets; otherwise the target is forced to IALIGN alignment.
module pc_gen #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000,
    parameter int unsigned     FETCH_BYTES = 4,
    parameter int unsigned     IALIGN      = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_valid,
    input  logic [XLEN-1:0] flush_addr,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_addr,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_addr,
    output logic            fetch_epoch,
    output logic            misalign_err,
    output logic [XLEN-1:0] err_addr
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    localparam logic [XLEN-1:0] FB_MASK = XLEN'(FETCH_BYTES - 1);
    localparam logic [XLEN-1:0] FB_STEP = XLEN'(FETCH_BYTES);
    localparam logic [XLEN-1:0] AL_MASK = XLEN'(IALIGN - 1);

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q;
    logic            epoch_q;
    logic            pend_v_q;
    logic            pend_f_q;
    logic [XLEN-1:0] pend_a_q;

    logic            fire;
    logic            blocked;
    logic            cand_v;
    logic            cand_f;
    logic [XLEN-1:0] cand_a;
    logic [XLEN-1:0] tgt;
    logic            mis;
    logic            apply;
    logic [XLEN-1:0] seq_addr;

    assign fire     = fetch_valid & fetch_ready;
    assign blocked  = fetch_valid & ~fetch_ready;
    assign apply    = cand_v & ~blocked;
    assign seq_addr = (addr_q & ~FB_MASK) + FB_STEP;

    // Pick the redirect to apply or hold: flush first, a pending flush
    // shields against new redirs, and a new redir replaces a pending one.
    always_comb begin
        cand_v = 1'b0;
        cand_f = 1'b0;
        cand_a = '0;
        if (flush_valid) begin
            cand_v = 1'b1;
            cand_f = 1'b1;
            cand_a = flush_addr;
        end else if (state_q != HALT) begin
            if (pend_v_q && pend_f_q) begin
                cand_v = 1'b1;
                cand_f = 1'b1;
                cand_a = pend_a_q;
            end else if (redir_valid) begin
                cand_v = 1'b1;
                cand_a = redir_addr;
            end else if (pend_v_q) begin
                cand_v = 1'b1;
                cand_a = pend_a_q;
            end
        end
    end

`ifdef PC_GEN_MISALIGN_TRAP_EN
    assign mis = |(cand_a & AL_MASK);
    assign tgt = cand_a;
`else
    assign mis = 1'b0;
    assign tgt = cand_a & ~AL_MASK;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= BOOT;
        else       state_q <= state_d;
    end

    // Next state: a misaligned apply halts, an aligned flush resumes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = (apply && mis) ? HALT : RUN;
            RUN:     state_d = (apply && mis) ? HALT : RUN;
            HALT:    state_d = (apply && !mis) ? RUN : HALT;
            default: state_d = BOOT;
        endcase
    end

    // Outputs decoded from state: a request is offered only in RUN.
    always_comb begin
        fetch_valid = (state_q == RUN);
    end

    // PC, epoch and pending slot: apply when unblocked, else hold pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= RESET_PC;
            epoch_q  <= 1'b0;
            pend_v_q <= 1'b0;
            pend_f_q <= 1'b0;
            pend_a_q <= '0;
        end else if (apply) begin
            pend_v_q <= 1'b0;
            if (!mis) begin
                addr_q  <= tgt;
                epoch_q <= ~epoch_q;
            end
        end else begin
            if (blocked && cand_v) begin
                pend_v_q <= 1'b1;
                pend_f_q <= cand_f;
                pend_a_q <= cand_a;
            end
            if (fire) addr_q <= seq_addr;
        end
    end

`ifdef PC_GEN_MISALIGN_TRAP_EN
    logic            err_q;
    logic [XLEN-1:0] err_addr_q;

    // Sticky error: set and logged on a misaligned apply, cleared on resume.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (apply) begin
            if (mis) begin
                err_q      <= 1'b1;
                err_addr_q <= cand_a;
            end else begin
                err_q      <= 1'b0;
            end
        end
    end

    assign misalign_err = err_q;
    assign err_addr     = err_addr_q;
`else
    assign misalign_err = 1'b0;
    assign err_addr     = '0;
`endif

    assign fetch_addr  = addr_q;
    assign fetch_epoch = epoch_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen (default and
// FETCH_BYTES=8 instances); expectations follow PC_GEN_MISALIGN_TRAP_EN.
module tb_pc_gen;

    typedef struct packed {
        logic [31:0] addr;
        logic        epoch;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_addr = '0;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_addr = '0;
    logic        fetch_valid;
    logic        fetch_ready = 1'b1;
    logic [31:0] fetch_addr;
    logic        fetch_epoch;
    logic        misalign_err;
    logic [31:0] err_addr;

    logic        reset8 = 1'b1;
    logic        redir8_valid = 1'b0;
    logic [31:0] redir8_addr = '0;
    logic        valid8;
    logic        ready8 = 1'b1;
    logic [31:0] addr8;
    logic        epoch8;
    logic        err8;
    logic [31:0] erra8;

    exp_t sb_q[$];
    exp_t sb8_q[$];
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk(clk), .reset(reset),
        .flush_valid(flush_valid), .flush_addr(flush_addr),
        .redir_valid(redir_valid), .redir_addr(redir_addr),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_addr(fetch_addr), .fetch_epoch(fetch_epoch),
        .misalign_err(misalign_err), .err_addr(err_addr)
    );

    pc_gen #(.FETCH_BYTES(8)) dut8 (
        .clk(clk), .reset(reset8),
        .flush_valid(1'b0), .flush_addr(32'h0),
        .redir_valid(redir8_valid), .redir_addr(redir8_addr),
        .fetch_valid(valid8), .fetch_ready(ready8),
        .fetch_addr(addr8), .fetch_epoch(epoch8),
        .misalign_err(err8), .err_addr(erra8)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic e);
        exp_t x;
        x.addr = a;
        x.epoch = e;
        sb_q.push_back(x);
    endtask

    task automatic push8(input logic [31:0] a, input logic e);
        exp_t x;
        x.addr = a;
        x.epoch = e;
        sb8_q.push_back(x);
    endtask

    // Monitor: every accepted request is checked against the scoreboard.
    always @(negedge clk) begin
        if (!reset && fetch_valid && fetch_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL fire_unexpected: got %h expected none", fetch_addr);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("fire_addr", fetch_addr, e.addr);
                chk("fire_epoch", {31'b0, fetch_epoch}, {31'b0, e.epoch});
            end
        end
    end

    always @(negedge clk) begin
        if (!reset8 && valid8 && ready8) begin
            if (sb8_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL fire8_unexpected: got %h expected none", addr8);
            end else begin
                exp_t e;
                e = sb8_q.pop_front();
                chk("fire8_addr", addr8, e.addr);
                chk("fire8_epoch", {31'b0, epoch8}, {31'b0, e.epoch});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // FETCH_BYTES=8 instance: block-aligned stepping after a redirect.
        push8(32'h8000_0000, 1'b0);
        push8(32'h8000_0008, 1'b0);
        push8(32'h8000_0004, 1'b1);
        push8(32'h8000_0008, 1'b1);
        step();
        reset8 = 1'b0;
        step();
        step();
        redir8_valid = 1'b1;
        redir8_addr  = 32'h8000_0004;
        step();
        redir8_valid = 1'b0;
        step();
        step();
        ready8 = 1'b0;
        chk("fb8_hold_addr", addr8, 32'h8000_0010);
        chk("fb8_err", {31'b0, err8}, 32'h0);
        chk("fb8_queue_empty", sb8_q.size(), 32'h0);

        // Main instance: reset values while reset is held.
        step();
        chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
        chk("rst_addr", fetch_addr, 32'h8000_0000);
        chk("rst_epoch", {31'b0, fetch_epoch}, 32'h0);
        chk("rst_err", {31'b0, misalign_err}, 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);

        push(32'h8000_0000, 1'b0);
        push(32'h8000_0004, 1'b0);
        push(32'h8000_0008, 1'b0);
        push(32'h8000_0100, 1'b1);
        push(32'h8000_0200, 1'b0);
        push(32'h8000_0204, 1'b0);
        push(32'hFFFF_FFF8, 1'b1);
        push(32'hFFFF_FFFC, 1'b1);
        push(32'h0000_0000, 1'b1);
`ifdef PC_GEN_MISALIGN_TRAP_EN
        push(32'h8000_0000, 1'b0);
`else
        push(32'h8000_0100, 1'b0);
`endif

        reset = 1'b0;
        chk("boot_valid", {31'b0, fetch_valid}, 32'h0);
        step();
        step();
        step();
        // Stall three cycles at 0x8000_0008 with a redir in the first.
        fetch_ready = 1'b0;
        redir_valid = 1'b1;
        redir_addr  = 32'h8000_0100;
        chk("stall_addr0", fetch_addr, 32'h8000_0008);
        step();
        redir_valid = 1'b0;
        chk("stall_addr1", fetch_addr, 32'h8000_0008);
        step();
        chk("stall_addr2", fetch_addr, 32'h8000_0008);
        chk("stall_epoch", {31'b0, fetch_epoch}, 32'h0);
        step();
        fetch_ready = 1'b1;
        step();
        // Flush and redir together while blocked; flush wins and is pending.
        fetch_ready = 1'b0;
        flush_valid = 1'b1;
        flush_addr  = 32'h8000_0200;
        redir_valid = 1'b1;
        redir_addr  = 32'h8000_0300;
        step();
        flush_valid = 1'b0;
        redir_addr  = 32'h8000_0400;
        chk("pend_hold_addr", fetch_addr, 32'h8000_0100);
        step();
        redir_valid = 1'b0;
        fetch_ready = 1'b1;
        step();
        step();
        // Unblocked redir coinciding with a fire; then wrap at 2^32.
        redir_valid = 1'b1;
        redir_addr  = 32'hFFFF_FFF8;
        step();
        redir_valid = 1'b0;
        step();
        step();
        redir_valid = 1'b1;
        redir_addr  = 32'h8000_0102;
        step();
        redir_valid = 1'b0;
`ifdef PC_GEN_MISALIGN_TRAP_EN
        chk("halt_valid", {31'b0, fetch_valid}, 32'h0);
        chk("halt_err", {31'b0, misalign_err}, 32'h1);
        chk("halt_err_addr", err_addr, 32'h8000_0102);
        redir_valid = 1'b1;
        redir_addr  = 32'h8000_0500;
        step();
        redir_valid = 1'b0;
        chk("halt_redir_ignored", {31'b0, fetch_valid}, 32'h0);
        flush_valid = 1'b1;
        flush_addr  = 32'h8000_0000;
        step();
        flush_valid = 1'b0;
        chk("resume_err", {31'b0, misalign_err}, 32'h0);
        step();
        fetch_ready = 1'b0;
        chk("resume_next", fetch_addr, 32'h8000_0004);
`else
        chk("noalign_err", {31'b0, misalign_err}, 32'h0);
        chk("noalign_err_addr", err_addr, 32'h0);
        step();
        fetch_ready = 1'b0;
        chk("noalign_next", fetch_addr, 32'h8000_0104);
`endif
        // Reset while stalled with a redir pending.
        redir_valid = 1'b1;
        redir_addr  = 32'h8000_0600;
        step();
        redir_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, fetch_valid}, 32'h0);
        chk("mid_rst_addr", fetch_addr, 32'h8000_0000);
        chk("mid_rst_epoch", {31'b0, fetch_epoch}, 32'h0);
        chk("mid_rst_err", {31'b0, misalign_err}, 32'h0);
        push(32'h8000_0000, 1'b0);
        push(32'h8000_0004, 1'b0);
        step();
        step();
        fetch_ready = 1'b1;
        reset = 1'b0;
        step();
        step();
        step();
        fetch_ready = 1'b0;
        chk("post_rst_addr", fetch_addr, 32'h8000_0008);
        step();
        step();
        chk("queue_empty", sb_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
